// File: rtl/uart_rx_stream_if.sv
// Byte stream carrying received UART bytes from the receiver to its consumer.
//   data  : head byte offered by the producer
//   valid : producer has a byte available
//   ready : consumer accepts the byte this cycle (qualified by the producer's clk_en)
// Modports: master = producer (uart_rx_stream), slave = consumer.
interface uart_rx_stream_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_stream.sv
// UART receiver, 8N1 LSB first, 16x oversampling, feeding a small receive FIFO
// that is presented as a valid/ready byte stream.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing with parity check.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clk_en         global enable; nothing advances while low
//   i_rxd          raw asynchronous serial line, idle high
//   m_stream       byte stream out (data = FIFO head, valid = FIFO non-empty, ready in)
//   o_frame_err    1-cycle pulse, stop bit sampled low
//   o_parity_err   1-cycle pulse, parity mismatch (constant 0 without the macro)
//   o_overrun      1-cycle pulse, good byte dropped because the FIFO was full
//   o_busy         receiver is inside a frame (not idle)
module uart_rx_stream #(
  parameter int unsigned PRESCALE   = 27,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             i_rxd,
  uart_rx_stream_if.master m_stream,
  output logic             o_frame_err,
  output logic             o_parity_err,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int unsigned TICK_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_BREAK  = 3'd4,
    S_PARITY = 3'd5
`else
    S_BREAK  = 3'd4
`endif
  } state_e;

  state_e              state_q, state_d;
  logic                rxd_m_q, rxd_m_d;
  logic                rxd_s_q, rxd_s_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]          samp_cnt_q, samp_cnt_d;
  logic [1:0]          vote_q, vote_d;
  logic                maj_q, maj_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                par_err_q, par_err_d;
  logic                parity_err_q, parity_err_d;
`endif

  logic                tick_c;
  logic                mid_c;
  logic                end_c;
  logic                maj_c;
  logic                push_c;
  logic                pop_c;
  logic                full_c;
  logic                valid_c;

  // FIFO status from the pointers: extra MSB distinguishes full from empty.
  always_comb begin
    valid_c = (wr_ptr_q != rd_ptr_q);
    full_c  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop_c   = clk_en && valid_c && m_stream.ready;
  end

  // Oversampling timebase, bit voting, receive FSM and FIFO next state.
  always_comb begin
    state_d    = state_q;
    rxd_m_d    = rxd_m_q;
    rxd_s_d    = rxd_s_q;
    tick_cnt_d = tick_cnt_q;
    samp_cnt_d = samp_cnt_q;
    vote_d     = vote_q;
    maj_d      = maj_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif

    if (clk_en) begin
      rxd_m_d = i_rxd;
      rxd_s_d = rxd_m_q;
    end

    tick_c = clk_en && (tick_cnt_q == TICK_W'(PRESCALE - 1));
    if (clk_en) begin
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    end
    if (tick_c) begin
      samp_cnt_d = samp_cnt_q + 4'd1;
    end

    // Samples 7 and 8 are stored; sample 9 is the live line value.
    if (tick_c && (samp_cnt_q == 4'd7)) vote_d[0] = rxd_s_q;
    if (tick_c && (samp_cnt_q == 4'd8)) vote_d[1] = rxd_s_q;
    maj_c = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s_q) | (vote_q[1] & rxd_s_q);
    mid_c = tick_c && (samp_cnt_q == 4'd9);
    end_c = tick_c && (samp_cnt_q == 4'd15);
    if (mid_c) maj_d = maj_c;

    case (state_q)
      S_IDLE: begin
        // Re-phase the timebase on the falling edge of the start bit.
        if (clk_en && !rxd_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          samp_cnt_d = '0;
        end
      end
      S_START: begin
        // Glitch rejected at mid-bit; a real start bit runs to its end before data.
        if (mid_c && maj_c) begin
          state_d = S_IDLE;
        end else if (end_c) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (end_c) begin
          shift_d   = {maj_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        // Even parity: data bits XOR parity bit must be zero.
        if (end_c) begin
          par_err_d = (^shift_q) ^ maj_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (mid_c) begin
          if (!maj_c) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
`endif
          end else begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (clk_en && rxd_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A push into a full FIFO lands only if the head leaves in the same cycle.
    if (push_c) begin
      if (!full_c || pop_c) begin
        mem_d[wr_ptr_q[ADDR_W-1:0]] = shift_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rxd_m_q     <= 1'b1;
      rxd_s_q     <= 1'b1;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      vote_q      <= 2'b11;
      maj_q       <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rxd_m_q     <= rxd_m_d;
      rxd_s_q     <= rxd_s_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      vote_q      <= vote_d;
      maj_q       <= maj_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Outputs; the stream head is read straight from storage.
  assign m_stream.data  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign m_stream.valid = valid_c;
  assign o_frame_err    = frame_err_q;
  assign o_overrun      = overrun_q;
  assign o_busy         = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err   = parity_err_q;
`else
  assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
`timescale 1ns/1ps
module tb_uart_rx_stream;
  localparam int unsigned P1    = 4;
  localparam int unsigned P2    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int          BIT   = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en1 = 1'b1;
  logic en2 = 1'b1;
  logic rxd1 = 1'b1;
  logic rxd2 = 1'b1;
  logic fe1, pe1, ov1, bz1;
  logic fe2, pe2, ov2, bz2;
  bit   rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_rx_stream_if s1 ();
  uart_rx_stream_if s2 ();

  uart_rx_stream #(.PRESCALE(P1), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .clk_en(en1), .i_rxd(rxd1), .m_stream(s1),
    .o_frame_err(fe1), .o_parity_err(pe1), .o_overrun(ov1), .o_busy(bz1)
  );

  uart_rx_stream #(.PRESCALE(P2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rst(rst), .clk_en(en2), .i_rxd(rxd2), .m_stream(s2),
    .o_frame_err(fe2), .o_parity_err(pe2), .o_overrun(ov2), .o_busy(bz2)
  );

  // Reference model state: bytes the receiver should deliver, and event counts.
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  int obs_fe = 0, obs_pe = 0, obs_ov = 0;
  int obs2_err = 0;
  int npops = 0, pops2 = 0, vcycles = 0;
  int total = 0, bad = 0;
  logic pv2 = 1'b0, pen2 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd2 = v;
    else     rxd1 = v;
  endtask

  // Model decision for a frame, made before its stop bit reaches the DUT.
  task automatic classify(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    if (!stop_bit)                     exp_fe++;
    else if (PAR_EN && par_bit != ^d)  exp_pe++;
    else if (exp_q.size() < DEPTH)     exp_q.push_back(d);
    else                               exp_ov++;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d,
                            input logic par_bit, input logic stop_bit);
    drive(sel, 1'b0);
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_clk(BIT);
    end
    if (PAR_EN) begin
      drive(sel, par_bit);
      wait_clk(BIT);
    end
    if (!sel) classify(d, par_bit, stop_bit);
    drive(sel, stop_bit);
    wait_clk(BIT);
  endtask

  // Scoreboard monitor for the main receiver.
  always @(negedge clk) begin
    if (!rst) begin
      if (s1.valid) vcycles++;
      if (en1 && s1.valid && s1.ready) begin
        npops++;
        if (exp_q.size() == 0) check("pop_with_nothing_expected", 1, 0);
        else                   check("pop_data", int'(s1.data), int'(exp_q.pop_front()));
      end
      if (fe1) obs_fe++;
      if (pe1) obs_pe++;
      if (ov1) obs_ov++;
    end
  end

  // Monitor for the clock-enable-toggled receiver.
  always @(negedge clk) begin
    if (!rst) begin
      if (pv2 && !s2.valid) check("t5_pop_on_enabled_cycle", int'(pen2), 1);
      if (en2 && s2.valid && s2.ready) begin
        pops2++;
        check("t5_data", int'(s2.data), 8'h55);
      end
      if (fe2 || pe2 || ov2) obs2_err++;
      pv2  = s2.valid;
      pen2 = en2;
    end
  end

  // Clock enable toggles every cycle for the second receiver.
  initial begin
    forever begin
      @(posedge clk);
      #1 en2 = ~en2;
    end
  end

  // Random consumer back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) s1.ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, vc0;
    logic [7:0] d;
    logic pb, sb;
    s1.ready = 1'b1;
    s2.ready = 1'b1;

    // Reset values
    rst = 1'b1;
    wait_clk(5);
    check("rst_valid", int'(s1.valid), 0);
    check("rst_data", int'(s1.data), 0);
    check("rst_busy", int'(bz1), 0);
    check("rst_frame_err", int'(fe1), 0);
    check("rst_parity_err", int'(pe1), 0);
    check("rst_overrun", int'(ov1), 0);
    rst = 1'b0;
    wait_clk(10);

    // 1: single byte, consumer ready
    vc0 = vcycles;
    send_frame(1'b0, 8'h6E, ^8'h6E, 1'b1);
    wait_clk(BIT);
    check("t1_valid_cycles", vcycles - vc0, 1);
    check("t1_pending", exp_q.size(), 0);
    check("t1_no_errors", obs_fe + obs_pe + obs_ov, 0);

    // 2: fill FIFO with consumer stalled, fifth byte overruns
    s1.ready = 1'b0;
    send_frame(1'b0, 8'h77, ^8'h77, 1'b1);
    send_frame(1'b0, 8'h72, ^8'h72, 1'b1);
    send_frame(1'b0, 8'h69, ^8'h69, 1'b1);
    send_frame(1'b0, 8'h74, ^8'h74, 1'b1);
    send_frame(1'b0, 8'h65, ^8'h65, 1'b1);
    wait_clk(BIT);
    check("t2_held_count", exp_q.size(), 4);
    check("t2_valid", int'(s1.valid), 1);
    check("t2_head", int'(s1.data), 8'h77);
    check("t2_overrun_pulses", obs_ov, 1);
    check("t2_overrun_model", obs_ov, exp_ov);
    s1.ready = 1'b1;
    wait_clk(4);
    check("t2_drained_consecutive", int'(s1.valid), 0);
    check("t2_pending", exp_q.size(), 0);

    // 3: short low glitch
    p0 = npops;
    f0 = obs_fe;
    rxd1 = 1'b0;
    wait_clk(10);
    check("t3_busy_during", int'(bz1), 1);
    wait_clk(10);
    rxd1 = 1'b1;
    wait_clk(BIT);
    check("t3_busy_after", int'(bz1), 0);
    check("t3_no_pop", npops - p0, 0);
    check("t3_no_frame_err", obs_fe - f0, 0);

    // 4: framing error, held break, then a good byte
    p0 = npops;
    f0 = obs_fe;
    send_frame(1'b0, 8'h41, ^8'h41, 1'b0);
    wait_clk(300);
    rxd1 = 1'b1;
    wait_clk(BIT);
    send_frame(1'b0, 8'h42, ^8'h42, 1'b1);
    wait_clk(BIT);
    check("t4_frame_err_once", obs_fe - f0, 1);
    check("t4_one_byte", npops - p0, 1);
    check("t4_pending", exp_q.size(), 0);

    // 5: clock enable toggling every cycle
    send_frame(1'b1, 8'h55, ^8'h55, 1'b1);
    wait_clk(2 * BIT);
    check("t5_pops", pops2, 1);
    check("t5_no_errors", obs2_err, 0);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch discarded, then correct parity accepted
    p0 = npops;
    send_frame(1'b0, 8'h03, 1'b1, 1'b1);
    wait_clk(BIT);
    check("t6_parity_err", obs_pe, 1);
    check("t6_nothing_pushed", npops - p0, 0);
    send_frame(1'b0, 8'h03, 1'b0, 1'b1);
    wait_clk(BIT);
    check("t6_received", npops - p0, 1);
`endif

    // 7: reset in the middle of a frame with a byte queued
    s1.ready = 1'b0;
    send_frame(1'b0, 8'h5A, ^8'h5A, 1'b1);
    wait_clk(BIT / 2);
    check("t7_queued", int'(s1.valid), 1);
    p0 = npops;
    rxd1 = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 3; i++) begin
      rxd1 = i[0] ? 1'b0 : 1'b1;
      wait_clk(BIT);
    end
    check("t7_busy_mid_frame", int'(bz1), 1);
    rst = 1'b1;
    rxd1 = 1'b1;
    wait_clk(1);
    exp_q.delete();
    check("t7_valid_after_rst", int'(s1.valid), 0);
    check("t7_busy_after_rst", int'(bz1), 0);
    rst = 1'b0;
    s1.ready = 1'b1;
    wait_clk(3 * BIT);
    check("t7_nothing_emitted", npops - p0, 0);

    // Random traffic with random back-pressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      sb = ($urandom_range(0, 7) != 0);
      send_frame(1'b0, d, pb, sb);
      rxd1 = 1'b1;
      wait_clk(sb ? int'($urandom_range(0, 40)) : 20 + int'($urandom_range(0, 40)));
    end
    rnd_rdy = 1'b0;
    s1.ready = 1'b1;
    wait_clk(3 * BIT);
    check("rnd_pending", exp_q.size(), 0);
    check("rnd_valid_idle", int'(s1.valid), 0);
    check("rnd_frame_errs", obs_fe, exp_fe);
    check("rnd_parity_errs", obs_pe, exp_pe);
    check("rnd_overruns", obs_ov, exp_ov);
    check("end_busy2", int'(bz2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
